// File: rtl/spi_pkg.sv
// Types and constants shared by the SPI shift engine and its register interface.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW
    } spi_state_t;

    // Bit positions inside the SPI_CNT control/status register
    localparam int SPI_CNT_BUSY_BIT   = 0;
    localparam int SPI_CNT_CSKEEP_BIT = 1;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter: counts H-1..0 and emits a one-cycle tick
// on the zero count, then reloads from the divider value latched at load.
module spi_clk_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            div_q   <= load_val;
            count_q <= load_val;
        end else if (count_q == '0) begin
            count_q <= div_q;
        end else begin
            count_q <= count_q - 1'b1;
        end
    end

    // Counting down from the stored value keeps H = 2^DIV_W reachable without overflow
    assign tick = (count_q == '0);

endmodule

// File: rtl/spi_shift_engine.sv
// Byte-wide SPI master shift engine, mode 0, MSB first. One FastClk domain,
// programmable SPI clock half-period, registered outputs throughout.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DIV_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              FastClk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] TxByte,
    input  logic [DIV_W-1:0]  ClkDiv,
    input  logic              CsKeep,
    output logic              Busy,
    output logic              Done,
    output logic              Overrun,
    output logic [DATA_W-1:0] RxByte,
    output logic              SPI_Cs,
    output logic              SPI_Clk,
    output logic              SPI_Do,
    input  logic              SPI_Di
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rx_byte_d;
    logic              accept;
    logic              tick;
    logic              busy_d, done_d, overrun_d;
    logic              cs_d, sclk_d, sdo_d;

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk      (FastClk),
        .rst      (Reset),
        .load     (accept),
        .load_val (ClkDiv),
        .tick     (tick)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_byte_d = RxByte;
        sclk_d    = SPI_Clk;
        sdo_d     = SPI_Do;
        done_d    = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_d   = LEAD;
                    bit_cnt_d = '0;
                    tx_d      = TxByte;
                    sdo_d     = TxByte[DATA_W-1];
                    sclk_d    = 1'b0;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                end
            end
            HIGH: begin
                if (tick) begin
                    // Sample MISO on the last high cycle, just before the falling edge
                    rx_d    = {rx_q[DATA_W-2:0], SPI_Di};
                    state_d = LOW;
                    sclk_d  = 1'b0;
                    if (bit_cnt_q != LAST_BIT) begin
                        tx_d  = tx_q << 1;
                        sdo_d = tx_q[DATA_W-2];
                    end
                end
            end
            LOW: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        rx_byte_d = rx_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = HIGH;
                        sclk_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_d = Start && (state_q != IDLE);
        busy_d    = (state_d != IDLE);
        cs_d      = ~(busy_d | CsKeep);
    end

    always_ff @(posedge FastClk) begin
        if (Reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Overrun   <= 1'b0;
            RxByte    <= '0;
            SPI_Cs    <= 1'b1;
            SPI_Clk   <= 1'b0;
            SPI_Do    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            Busy      <= busy_d;
            Done      <= done_d;
            Overrun   <= overrun_d;
            RxByte    <= rx_byte_d;
            SPI_Cs    <= cs_d;
            SPI_Clk   <= sclk_d;
            SPI_Do    <= sdo_d;
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: table of directed transfers plus
// hand-written sequences for idle /CS control, mid-transfer reset and back-to-back.
module tb_spi_shift_engine;

    logic       FastClk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] TxByte;
    logic [3:0] ClkDiv;
    logic       CsKeep;
    logic       Busy;
    logic       Done;
    logic       Overrun;
    logic [7:0] RxByte;
    logic       SPI_Cs;
    logic       SPI_Clk;
    logic       SPI_Do;
    logic       SPI_Di;

    int n_cmp = 0;
    int n_bad = 0;

    always #20 FastClk = ~FastClk;

    spi_shift_engine #(
        .DIV_W  (4),
        .DATA_W (8)
    ) dut (
        .FastClk (FastClk),
        .Reset   (Reset),
        .Start   (Start),
        .TxByte  (TxByte),
        .ClkDiv  (ClkDiv),
        .CsKeep  (CsKeep),
        .Busy    (Busy),
        .Done    (Done),
        .Overrun (Overrun),
        .RxByte  (RxByte),
        .SPI_Cs  (SPI_Cs),
        .SPI_Clk (SPI_Clk),
        .SPI_Do  (SPI_Do),
        .SPI_Di  (SPI_Di)
    );

    // Mode-0 slave: captures MOSI on rising SPI_Clk, shifts MISO after each falling edge
    int         rise_count = 0;
    int         fall_count = 0;
    int         fall_base  = 0;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] slave_rx   = 8'h00;

    always @(posedge SPI_Clk) begin
        rise_count <= rise_count + 1;
        slave_rx   <= {slave_rx[6:0], SPI_Do};
    end

    always @(negedge SPI_Clk) fall_count <= fall_count + 1;

    always_comb begin : slave_out
        int k;
        k = fall_count - fall_base;
        if (k >= 0 && k < 8) SPI_Di = slave_byte[3'(7 - k)];
        else                 SPI_Di = 1'b0;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge FastClk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sl;
        logic [3:0] div;
        logic       keep;
        int         extra;
        int         exp_busy;
        int         exp_done;
        int         exp_ovr_cyc;
        int         exp_ovr_cnt;
        logic [7:0] exp_rx;
        logic       exp_cs_done;
        int         exp_w;
    } vec_t;

    typedef struct {
        int         busy_len;
        int         done_cyc;
        logic [7:0] rx;
        logic [7:0] cap;
        int         rises;
        int         min_w;
        int         max_w;
        logic       cs_low_all;
        logic       cs_done;
        int         ovr_cyc;
        int         ovr_cnt;
        logic       do_first;
        logic       do_done;
    } res_t;

    // Starts a transfer in the current cycle (cycle 0) and follows it to Done
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sl, input logic [3:0] div,
                            input logic keep, input int extra, output res_t r);
        int   rise0;
        int   run;
        logic lvl;
        r.busy_len   = 0;
        r.done_cyc   = -1;
        r.rx         = 8'h00;
        r.cap        = 8'h00;
        r.rises      = 0;
        r.min_w      = 1 << 30;
        r.max_w      = 0;
        r.cs_low_all = 1'b1;
        r.cs_done    = 1'b0;
        r.ovr_cyc    = -1;
        r.ovr_cnt    = 0;
        r.do_first   = 1'b0;
        r.do_done    = 1'b0;
        lvl          = 1'b0;
        run          = 0;
        slave_byte   = sl;
        fall_base    = fall_count;
        rise0        = rise_count;
        TxByte       = tx;
        ClkDiv       = div;
        CsKeep       = keep;
        Start        = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            step();
            if (cyc == 1) begin
                Start      = 1'b0;
                r.do_first = SPI_Do;
            end
            if (cyc == 2) begin
                TxByte = ~tx;
                ClkDiv = div ^ 4'hF;
            end
            if (extra > 0 && cyc == extra)     Start = 1'b1;
            if (extra > 0 && cyc == extra + 1) Start = 1'b0;
            if (Overrun) begin
                r.ovr_cnt++;
                if (r.ovr_cyc < 0) r.ovr_cyc = cyc;
            end
            if (Busy) begin
                r.busy_len++;
                if (SPI_Cs !== 1'b0) r.cs_low_all = 1'b0;
                if (run == 0) begin
                    lvl = SPI_Clk;
                    run = 1;
                end else if (SPI_Clk == lvl) begin
                    run++;
                end else begin
                    if (run < r.min_w) r.min_w = run;
                    if (run > r.max_w) r.max_w = run;
                    lvl = SPI_Clk;
                    run = 1;
                end
            end
            if (Done) begin
                if (run > 0) begin
                    if (run < r.min_w) r.min_w = run;
                    if (run > r.max_w) r.max_w = run;
                end
                r.done_cyc = cyc;
                r.rx       = RxByte;
                r.cs_done  = SPI_Cs;
                r.do_done  = SPI_Do;
                break;
            end
        end
        Start   = 1'b0;
        r.rises = rise_count - rise0;
        r.cap   = slave_rx;
    endtask

    vec_t vecs[5];
    res_t r;
    res_t r2;

    initial begin
        int   rise0;
        logic found;

        vecs[0] = '{8'hD3, 8'hAB, 4'h0, 1'b1, 0, 17,  18,  -1, 0, 8'hAB, 1'b0, 1};
        vecs[1] = '{8'h4A, 8'h13, 4'h0, 1'b0, 0, 17,  18,  -1, 0, 8'h13, 1'b1, 1};
        vecs[2] = '{8'hC5, 8'h3C, 4'h3, 1'b0, 0, 68,  69,  -1, 0, 8'h3C, 1'b1, 4};
        vecs[3] = '{8'h96, 8'h69, 4'h0, 1'b1, 5, 17,  18,   6, 1, 8'h69, 1'b0, 1};
        vecs[4] = '{8'h81, 8'h7E, 4'hF, 1'b0, 0, 272, 273, -1, 0, 8'h7E, 1'b1, 16};

        Reset  = 1'b1;
        Start  = 1'b0;
        TxByte = 8'h00;
        ClkDiv = 4'h0;
        CsKeep = 1'b0;
        repeat (2) step();
        check("reset SPI_Cs",  SPI_Cs,  1'b1);
        check("reset SPI_Clk", SPI_Clk, 1'b0);
        check("reset SPI_Do",  SPI_Do,  1'b0);
        check("reset Busy",    Busy,    1'b0);
        check("reset Done",    Done,    1'b0);
        check("reset Overrun", Overrun, 1'b0);
        check("reset RxByte",  RxByte,  8'h00);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i].tx, vecs[i].sl, vecs[i].div, vecs[i].keep, vecs[i].extra, r);
            check($sformatf("v%0d busy_len", i),   r.busy_len,   vecs[i].exp_busy);
            check($sformatf("v%0d done_cycle", i), r.done_cyc,   vecs[i].exp_done);
            check($sformatf("v%0d RxByte", i),     r.rx,         vecs[i].exp_rx);
            check($sformatf("v%0d slave_rx", i),   r.cap,        vecs[i].tx);
            check($sformatf("v%0d sclk_rises", i), r.rises,      8);
            check($sformatf("v%0d min_phase", i),  r.min_w,      vecs[i].exp_w);
            check($sformatf("v%0d max_phase", i),  r.max_w,      vecs[i].exp_w);
            check($sformatf("v%0d cs_low", i),     r.cs_low_all, 1'b1);
            check($sformatf("v%0d cs_done", i),    r.cs_done,    vecs[i].exp_cs_done);
            check($sformatf("v%0d ovr_cycle", i),  r.ovr_cyc,    vecs[i].exp_ovr_cyc);
            check($sformatf("v%0d ovr_count", i),  r.ovr_cnt,    vecs[i].exp_ovr_cnt);
            check($sformatf("v%0d do_first", i),   r.do_first,   vecs[i].tx[7]);
            check($sformatf("v%0d do_hold", i),    r.do_done,    vecs[i].tx[0]);
            step();
            check($sformatf("v%0d done_pulse", i), Done, 1'b0);
            check($sformatf("v%0d idle_busy", i),  Busy, 1'b0);
        end

        // /CS follows CsKeep alone while idle
        CsKeep = 1'b1;
        step();
        check("idle cs keep=1", SPI_Cs, 1'b0);
        CsKeep = 1'b0;
        step();
        check("idle cs keep=0", SPI_Cs, 1'b1);

        // Abort with reset while SPI_Clk is high after the 3rd rising edge
        slave_byte = 8'h5A;
        fall_base  = fall_count;
        rise0      = rise_count;
        TxByte     = 8'hA5;
        ClkDiv     = 4'h1;
        CsKeep     = 1'b1;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rise_count - rise0 == 3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("abort reached 3rd rise", found, 1'b1);
        Reset = 1'b1;
        step();
        check("abort SPI_Cs",  SPI_Cs,  1'b1);
        check("abort SPI_Clk", SPI_Clk, 1'b0);
        check("abort SPI_Do",  SPI_Do,  1'b0);
        check("abort Busy",    Busy,    1'b0);
        check("abort Done",    Done,    1'b0);
        check("abort RxByte",  RxByte,  8'h00);
        Reset = 1'b0;

        // Transfer after abort, then a second Start issued in its Done cycle
        run_xfer(8'h55, 8'hC3, 4'h0, 1'b1, 0, r);
        check("post-abort done_cycle", r.done_cyc, 18);
        check("post-abort busy_len",   r.busy_len, 17);
        check("post-abort RxByte",     r.rx,       8'hC3);
        check("post-abort slave_rx",   r.cap,      8'h55);
        check("post-abort cs_done",    r.cs_done,  1'b0);
        run_xfer(8'hA6, 8'h5A, 4'h0, 1'b1, 0, r2);
        check("b2b done_cycle", r2.done_cyc,   18);
        check("b2b busy_len",   r2.busy_len,   17);
        check("b2b RxByte",     r2.rx,         8'h5A);
        check("b2b slave_rx",   r2.cap,        8'hA6);
        check("b2b cs_low",     r2.cs_low_all, 1'b1);
        check("b2b cs_done",    r2.cs_done,    1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
